// File: rtl/io_bus_pkg.sv
// Shared types and width helpers for the external I/O bus bridge.
// Data width is a power of two of at least 16 bits, carved into 8-bit lanes.
package io_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    function automatic int lanes_of(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int lane_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/io_lane_steer.sv
// Byte-lane steering: lane mask from access size/low address bits, write data
// placement onto lanes, and read data extraction with zero extension. Pure combinational.
module io_lane_steer #(
    parameter int DATA_W = 16,
    parameter int LANES  = 2,
    parameter int LB     = 1
) (
    input  logic              word,
    input  logic [LB-1:0]     addr_lo,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata_raw,
    output logic [LANES-1:0]  lane_mask,
    output logic [DATA_W-1:0] wdata_lanes,
    output logic [DATA_W-1:0] rdata_ext
);

    always_comb begin
        lane_mask   = '0;
        wdata_lanes = '0;
        rdata_ext   = '0;
        for (int i = 0; i < LANES; i++) begin
            if (word || addr_lo == LB'(i)) begin
                lane_mask[i] = 1'b1;
            end
            // Byte writes carry the low byte on whichever lane is selected.
            if (lane_mask[i]) begin
                wdata_lanes[8*i +: 8] = word ? wdata[8*i +: 8] : wdata[7:0];
            end
            if (addr_lo == LB'(i)) begin
                rdata_ext[7:0] = rdata_raw[8*i +: 8];
            end
        end
        if (word) begin
            rdata_ext = rdata_raw;
        end
    end

endmodule

// File: rtl/io_bus_interface.sv
// Bridges single CPU requests onto a setup/strobe/hold external bus with wait states.
// Accepts one request at a time (req_ready only in IDLE); ext_ready low stretches the strobe.
module io_bus_interface
    import io_bus_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int WAIT_W = 4,
    localparam int LANES = lanes_of(DATA_W),
    localparam int LB    = lane_bits(DATA_W)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_word,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [WAIT_W-1:0] wait_states,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-LB-1:0] ext_addr,
    output logic [DATA_W-1:0] ext_data_out,
    output logic [LANES-1:0]  ext_data_oe,
    input  logic [DATA_W-1:0] ext_data_in,
    output logic              ext_rd_n,
    output logic              ext_wr_n,
    output logic [LANES-1:0]  ext_cs_n,
    input  logic              ext_ready
);

    state_t              state_q, state_d;
    logic                write_q, write_d;
    logic                word_q, word_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;

    logic [LANES-1:0]    lane_mask;
    logic [DATA_W-1:0]   wdata_lanes;
    logic [DATA_W-1:0]   rdata_ext;
    logic                active;

    io_lane_steer #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .LB     (LB)
    ) u_steer (
        .word        (word_q),
        .addr_lo     (addr_q[LB-1:0]),
        .wdata       (wdata_q),
        .rdata_raw   (ext_data_in),
        .lane_mask   (lane_mask),
        .wdata_lanes (wdata_lanes),
        .rdata_ext   (rdata_ext)
    );

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        word_d  = word_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = SETUP;
                    write_d = req_write;
                    word_d  = req_word;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = wait_states;
                end
            end
            SETUP: state_d = STROBE;
            STROBE: begin
                // Count down first; ext_ready only matters once the count is spent.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end else if (ext_ready) begin
                    state_d = HOLD;
                    if (!write_q) begin
                        rdata_d = rdata_ext;
                    end
                end
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            word_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign active       = (state_q != IDLE);
    assign req_ready    = (state_q == IDLE);
    assign rsp_valid    = (state_q == HOLD);
    assign rsp_rdata    = rdata_q;
    assign ext_addr     = active ? addr_q[ADDR_W-1:LB] : '0;
    assign ext_cs_n     = active ? ~lane_mask : '1;
    assign ext_data_oe  = (active && write_q) ? lane_mask : '0;
    assign ext_data_out = (active && write_q) ? wdata_lanes : '0;
    assign ext_rd_n     = !((state_q == STROBE) && !write_q);
    assign ext_wr_n     = !((state_q == STROBE) && write_q);

endmodule

// File: tb/tb_io_bus_interface.sv
// Drives a 16-bit and a 32-bit bridge with directed and random accesses and
// checks every bus cycle against an arithmetic model of the access protocol.
module tb_io_bus_interface;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        v16 = 1'b0, v32 = 1'b0;
    logic        req_write = 1'b0, req_word = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  wait_states = '0;
    logic [31:0] din_bus = '0;
    logic        ext_ready = 1'b1;

    logic        r16_rdy, r16_vld, r16_rd_n, r16_wr_n;
    logic [15:0] r16_rdata, r16_dout;
    logic [14:0] r16_addr;
    logic [1:0]  r16_oe, r16_cs_n;
    logic        r32_rdy, r32_vld, r32_rd_n, r32_wr_n;
    logic [31:0] r32_rdata, r32_dout;
    logic [13:0] r32_addr;
    logic [3:0]  r32_oe, r32_cs_n;

    int vectors = 0;
    int miscompares = 0;
    logic sel = 1'b0;
    logic [31:0] last_rd [2];

    always #5 clock = ~clock;

    io_bus_interface #(.DATA_W(16), .ADDR_W(16), .WAIT_W(4)) d16 (
        .clock(clock), .reset(reset), .req_valid(v16), .req_ready(r16_rdy),
        .req_write(req_write), .req_word(req_word), .req_addr(req_addr),
        .req_wdata(req_wdata[15:0]), .wait_states(wait_states),
        .rsp_valid(r16_vld), .rsp_rdata(r16_rdata), .ext_addr(r16_addr),
        .ext_data_out(r16_dout), .ext_data_oe(r16_oe), .ext_data_in(din_bus[15:0]),
        .ext_rd_n(r16_rd_n), .ext_wr_n(r16_wr_n), .ext_cs_n(r16_cs_n), .ext_ready(ext_ready)
    );

    io_bus_interface #(.DATA_W(32), .ADDR_W(16), .WAIT_W(4)) d32 (
        .clock(clock), .reset(reset), .req_valid(v32), .req_ready(r32_rdy),
        .req_write(req_write), .req_word(req_word), .req_addr(req_addr),
        .req_wdata(req_wdata), .wait_states(wait_states),
        .rsp_valid(r32_vld), .rsp_rdata(r32_rdata), .ext_addr(r32_addr),
        .ext_data_out(r32_dout), .ext_data_oe(r32_oe), .ext_data_in(din_bus),
        .ext_rd_n(r32_rd_n), .ext_wr_n(r32_wr_n), .ext_cs_n(r32_cs_n), .ext_ready(ext_ready)
    );

    // Selected instance's outputs, zero-padded to 32-bit view
    logic [31:0] o_dout, o_addr, o_rdata;
    logic [3:0]  o_cs_n, o_oe;
    logic        o_rdy, o_vld, o_rd_n, o_wr_n;
    always_comb begin
        if (sel) begin
            o_dout = r32_dout;  o_addr = {18'b0, r32_addr}; o_rdata = r32_rdata;
            o_cs_n = r32_cs_n;  o_oe = r32_oe;
            o_rdy = r32_rdy; o_vld = r32_vld; o_rd_n = r32_rd_n; o_wr_n = r32_wr_n;
        end else begin
            o_dout = {16'b0, r16_dout}; o_addr = {17'b0, r16_addr}; o_rdata = {16'b0, r16_rdata};
            o_cs_n = {2'b00, r16_cs_n}; o_oe = {2'b00, r16_oe};
            o_rdy = r16_rdy; o_vld = r16_vld; o_rd_n = r16_rd_n; o_wr_n = r16_wr_n;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // flags = {req_ready, rsp_valid, rd_n, wr_n}
    task automatic check_bus(input string tag, input logic [3:0] flags, input logic [3:0] cs_n,
                             input logic [3:0] oe, input logic [31:0] addr);
        chk({tag, "_flags"}, {28'b0, o_rdy, o_vld, o_rd_n, o_wr_n}, {28'b0, flags});
        chk({tag, "_cs_n"}, {28'b0, o_cs_n}, {28'b0, cs_n});
        chk({tag, "_oe"}, {28'b0, o_oe}, {28'b0, oe});
        chk({tag, "_addr"}, o_addr, addr);
    endtask

    task automatic check_reset_state(input logic s);
        int L;
        L = s ? 4 : 2;
        sel = s;
        #1;
        check_bus("rst", 4'b1011, 4'((1 << L) - 1), 4'b0, 32'b0);
        chk("rst_dout", o_dout, 32'b0);
        chk("rst_rdata", o_rdata, 32'b0);
    endtask

    task automatic do_access(input logic s, input logic wr, input logic wd, input logic [15:0] addr,
                             input logic [31:0] wdata, input int w, input int rlow,
                             input logic [31:0] din);
        int L, n;
        logic [3:0]  full, mask, cs_act, oe_exp;
        logic [31:0] dmask, exp_dout, exp_rd, exp_addr;
        L = s ? 4 : 2;
        full = 4'((1 << L) - 1);
        mask = wd ? full : 4'(1 << (addr % L));
        cs_act = ~mask & full;
        oe_exp = wr ? mask : 4'b0;
        exp_addr = 32'(addr) / L;
        dmask = '0;
        exp_dout = '0;
        for (int k = 0; k < L; k++) begin
            if (mask[k]) begin
                dmask[8*k +: 8] = 8'hFF;
                exp_dout[8*k +: 8] = wd ? wdata[8*k +: 8] : wdata[7:0];
            end
        end
        if (wd) exp_rd = (L == 4) ? din : (din & 32'h0000FFFF);
        else    exp_rd = (din >> (8 * (addr % L))) & 32'hFF;

        sel = s;
        @(negedge clock);
        chk("idle_ready_pre", {31'b0, o_rdy}, 32'd1);
        req_write = wr; req_word = wd; req_addr = addr; req_wdata = wdata;
        wait_states = 4'(w);
        if (s) v32 = 1'b1; else v16 = 1'b1;
        @(posedge clock); @(negedge clock);
        v16 = 1'b0; v32 = 1'b0;
        // Disturb request inputs: the access in flight must not follow them
        req_write = 1'($urandom); req_word = 1'($urandom); req_addr = 16'($urandom);
        req_wdata = $urandom; wait_states = 4'($urandom);
        check_bus("setup", 4'b0011, cs_act, oe_exp, exp_addr);
        if (wr) chk("setup_dout", o_dout & dmask, exp_dout);
        @(posedge clock); @(negedge clock);
        n = w + 1 + rlow;
        for (int c = 0; c < n; c++) begin
            ext_ready = (c < w) ? 1'($urandom) : ((c - w < rlow) ? 1'b0 : 1'b1);
            din_bus = (c == n - 1) ? din : $urandom;
            check_bus("strobe", {2'b00, wr, ~wr}, cs_act, oe_exp, exp_addr);
            if (wr) chk("strobe_dout", o_dout & dmask, exp_dout);
            @(posedge clock); @(negedge clock);
        end
        ext_ready = 1'b1;
        din_bus = $urandom;
        if (!wr) last_rd[s] = exp_rd;
        check_bus("hold", 4'b0111, cs_act, oe_exp, exp_addr);
        chk("hold_rdata", o_rdata, last_rd[s]);
        @(posedge clock); @(negedge clock);
        check_bus("idle", 4'b1011, full, 4'b0, 32'b0);
        chk("idle_rdata", o_rdata, last_rd[s]);
    endtask

    initial begin
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_state(1'b0);
        check_reset_state(1'b1);
        reset = 1'b0;

        // Reset during the strobe of a write, with req_valid held through reset
        sel = 1'b0;
        @(negedge clock);
        req_write = 1'b1; req_word = 1'b1; req_addr = 16'h0040; req_wdata = 32'h5A5A;
        wait_states = 4'd5;
        v16 = 1'b1;
        @(posedge clock); @(negedge clock);
        v16 = 1'b0;
        @(posedge clock); @(negedge clock);
        chk("pre_reset_wr_n", {31'b0, o_wr_n}, 32'd0);
        reset = 1'b1;
        v16 = 1'b1;
        wait_states = 4'd0;
        @(posedge clock); @(negedge clock);
        check_reset_state(1'b0);
        @(posedge clock); @(negedge clock);
        reset = 1'b0;
        @(posedge clock); @(negedge clock);
        v16 = 1'b0;
        check_bus("post_rst_setup", 4'b0011, 4'b0000, 4'b0011, 32'h0020);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_bus("post_rst_idle", 4'b1011, 4'b0011, 4'b0000, 32'b0);

        // Directed accesses
        do_access(1'b0, 1'b1, 1'b1, 16'h0121, 32'h0000ABCD, 0, 0, $urandom);
        do_access(1'b0, 1'b1, 1'b0, 16'h0120, 32'h000012CD, 0, 0, $urandom);
        do_access(1'b0, 1'b1, 1'b0, 16'h0121, 32'h000012CD, 0, 0, $urandom);
        do_access(1'b0, 1'b0, 1'b0, 16'hF4D6, $urandom, 1, 0, 32'h0000EA53);
        do_access(1'b0, 1'b0, 1'b0, 16'hF4D3, $urandom, 0, 1, 32'h0000EA53);
        do_access(1'b0, 1'b0, 1'b1, 16'h1234, $urandom, 3, 2, 32'h00009C17);
        do_access(1'b0, 1'b1, 1'b0, 16'h0022, 32'h00000077, 15, 0, $urandom);
        do_access(1'b1, 1'b1, 1'b0, 16'h0003, 32'h123456CD, 0, 0, $urandom);
        do_access(1'b1, 1'b0, 1'b0, 16'h0003, $urandom, 2, 1, 32'hA1B2C3D4);
        do_access(1'b1, 1'b1, 1'b1, 16'h0003, 32'hCAFEF00D, 1, 0, $urandom);
        do_access(1'b1, 1'b0, 1'b1, 16'h0008, $urandom, 15, 3, 32'h89ABCDEF);

        // Random accesses on both widths
        for (int i = 0; i < 40; i++) begin
            do_access(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), $urandom,
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/io_bus_interface.md
# io_bus_interface

Parametrised successor to the ESC64 I/O interface. It bridges the CPU's internal request side to an external asynchronous-style memory/peripheral bus of configurable width. Each access runs as a registered multi-phase cycle (setup, strobe, hold) with a programmable wait-state count and an external ready extension. Byte-lane steering covers any power-of-two data width.

## Interface
- DATA_W, 16, data width in bits; power of two, ≥16; LANES = DATA_W/8, LB = log2(LANES)
- ADDR_W, 16, internal byte-address width; external word address is ADDR_W-LB bits
- WAIT_W, 4, width of wait-state count
- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  access request
- req_ready  out  1  high only in IDLE; transfer on req_valid && req_ready
- req_write  in  1  1 write, 0 read
- req_word  in  1  1 full-width access, 0 byte access
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data; byte access uses [7:0]
- wait_states  in  WAIT_W  extra strobe cycles, sampled at accept
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid; byte reads zero-extended
- ext_addr  out  ADDR_W-LB  req_addr >> LB
- ext_data_out  out  DATA_W  write data, lane-steered
- ext_data_oe  out  LANES  per-lane output enable
- ext_data_in  in  DATA_W  read data from bus
- ext_rd_n, ext_wr_n  out  1  active-low strobes
- ext_cs_n  out  LANES  active-low per-lane chip selects; lane i = bits [8i+7:8i]
- ext_ready  in  1  device ready; low extends strobe

## Operation
- States: IDLE, SETUP, STROBE, HOLD. IDLE→SETUP on accept; SETUP→STROBE always; STROBE→HOLD when wait counter = 0 and ext_ready = 1; HOLD→IDLE always.
- On accept, the block latches write, word, addr, wdata and wait_states. Later changes on req_* do not affect the access in flight.
- Lane selection: word access enables all lanes and ignores addr[LB-1:0]. Byte access enables only lane addr[LB-1:0].
- Writes: ext_data_out lane k carries wdata[8k+7:8k] for word access. For byte access, the selected lane carries wdata[7:0] and the other lanes' oe stays 0. ext_data_oe equals the lane mask from SETUP through HOLD, and is 0 otherwise and for reads.
- Reads: sampled from ext_data_in at the edge that leaves STROBE. Byte read returns the selected lane in rsp_rdata[7:0] with upper bits 0.
- ext_cs_n and ext_addr are driven from SETUP through HOLD. Outside an access, all cs_n = 1 and ext_addr = 0.
- Exactly one of ext_rd_n/ext_wr_n is low, and only in STROBE.
- rsp_rdata holds its value until the next read completes. Write completions leave it unchanged.

## Timing
- All outputs are registered or decoded from the registered state only; no combinational path from req_* or ext_* to outputs.
- For an accept at edge k with wait_states = W and ext_ready held high: SETUP is cycle k+1, STROBE is cycles k+2..k+2+W (W+1 cycles), HOLD with rsp_valid = 1 is cycle k+3+W, and IDLE with req_ready = 1 is cycle k+4+W.
- Minimum spacing between back-to-back accepts is W+4 cycles.
- ext_ready is sampled only in STROBE once the counter reaches 0. Each low sample adds one STROBE cycle. There is no timeout.
- wait_states = 0 gives a one-cycle strobe. wait_states = 2^WAIT_W-1 must not wrap the counter.
- Reset, including mid-access: the next cycle is IDLE with req_ready = 1, rsp_valid = 0, rsp_rdata = 0, strobes = 1, cs_n = all 1, oe = 0, ext_addr = 0, ext_data_out = 0. No rsp_valid is issued for an aborted access.
- If req_valid is held high during reset, it is accepted on the first edge after reset deasserts.

## Structure
- Package io_bus_pkg holds the state enum (IDLE/SETUP/STROBE/HOLD) and functions lanes_of(DATA_W) and lane_bits(DATA_W).
- Sub-module io_lane_steer (combinational) produces the lane mask from word/addr low bits, replicates write data, and extracts/zero-extends read data.
- Top level holds the FSM, wait counter and latches.

## Test plan
- Reset mid-STROBE of a write: next cycle ext_wr_n = 1, cs_n = 2'b11, oe = 0, req_ready = 1, no rsp_valid.
- Word write, DATA_W = 16, addr 16'h0121, wdata 16'hABCD, W = 0:
  - ext_addr = 15'h0090, cs_n = 2'b00, ext_data_out = 16'hABCD, oe = 2'b11.
  - wr_n is low for exactly cycle k+2; rsp_valid is high at k+3.
- Byte writes, wdata 16'hXXCD:
  - addr 16'h0120 gives cs_n = 2'b10, oe = 2'b01, lane 0 = 8'hCD.
  - addr 16'h0121 gives cs_n = 2'b01, oe = 2'b10, lane 1 = 8'hCD.
- Byte reads with ext_data_in = 16'hEA53:
  - addr 16'hF4D6 gives rsp_rdata = 16'h0053.
  - addr 16'hF4D3 gives rsp_rdata = 16'h00EA.
- Word read with W = 3 and ext_ready low for 2 cycles after the counter expires: rd_n is low for 6 cycles, then rsp_rdata = ext_data_in sampled on the last STROBE edge.
- Same access sequence at DATA_W = 32, ADDR_W = 16 with byte addr 16'h0003: ext_addr = 14'h0000, cs_n = 4'b0111, and a read returns lane 3 zero-extended.
